// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants, state encoding and baud divider helper for the
//            parametrised UART blocks.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

    // Clocks per oversample tick, rounded to nearest and never below 1.
    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        int denom;
        int div;
        denom = baud * oversample;
        div   = (clk_hz + denom / 2) / denom;
        return (div < 1) ? 1 : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_os_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_os_tick
// Brief    : Enable-gated, restartable oversample tick generator; one-clock
//            pulse every DIV clocks while enabled.
// Revision : 1.0 - initial release
// ============================================================================
module uart_os_tick #(
    parameter int DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int              c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!enable || restart || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = enable && !restart && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised UART receiver with majority-vote sampling, glitch
//            rejection, break detection and valid/ready output holding stage.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = PARITY_NONE,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_data,
    output logic [DATA_BITS-1:0] rx_word,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err
);

    localparam int               c_div      = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int               c_tcw      = $clog2(OVERSAMPLE);
    localparam int               c_bcw      = $clog2(DATA_BITS);
    localparam logic [c_tcw-1:0] c_tc_s0    = c_tcw'(OVERSAMPLE / 2 - 1);
    localparam logic [c_tcw-1:0] c_tc_s1    = c_tcw'(OVERSAMPLE / 2);
    localparam logic [c_tcw-1:0] c_tc_dec   = c_tcw'(OVERSAMPLE / 2 + 1);
    localparam logic [c_tcw-1:0] c_tc_last  = c_tcw'(OVERSAMPLE - 1);
    localparam logic [c_bcw-1:0] c_bit_last = c_bcw'(DATA_BITS - 1);
    localparam logic             c_stop_last = 1'(STOP_BITS - 1);

    logic                 r_sync1, r_sync2, r_rxs_d;
    uart_state_e          r_state;
    logic [c_tcw-1:0]     r_tc;
    logic [c_bcw-1:0]     r_bitcnt;
    logic                 r_stopcnt;
    logic                 r_s0, r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit, r_perr, r_ferr;
    logic [DATA_BITS-1:0] r_word;
    logic                 r_valid, r_perr_o, r_ferr_o, r_brk_o, r_ovr;

    logic w_rxs, w_tick, w_start_edge, w_majority, w_decide, w_bit_end;
    logic w_par_exp, w_deliver, w_ferr_final, w_brk, w_xfer;

    assign w_rxs        = r_sync2;
    assign w_start_edge = (r_state == IDLE) && r_rxs_d && !w_rxs;
    assign w_majority   = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_decide     = w_tick && (r_tc == c_tc_dec);
    assign w_bit_end    = w_tick && (r_tc == c_tc_last);
    assign w_par_exp    = (PARITY_MODE == PARITY_ODD) ? ~(^r_shift) : ^r_shift;
    assign w_deliver    = (r_state == STOP) && w_decide && (r_stopcnt == c_stop_last);
    assign w_ferr_final = r_ferr | ~w_majority;
    // A parity bit that was sampled high means the line was not a plain break.
    assign w_brk        = w_ferr_final && (r_shift == '0) &&
                          ((PARITY_MODE == PARITY_NONE) || !r_par_bit);
    assign w_xfer       = r_valid & rx_ready;

    uart_os_tick #(
        .DIV(c_div)
    ) u_os_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (r_state != IDLE),
        .restart(w_start_edge),
        .tick   (w_tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rxs_d   <= 1'b1;
            r_state   <= IDLE;
            r_tc      <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync1 <= rx_data;
            r_sync2 <= r_sync1;
            r_rxs_d <= w_rxs;
            if (w_tick) begin
                if (r_tc == c_tc_s0) r_s0 <= w_rxs;
                if (r_tc == c_tc_s1) r_s1 <= w_rxs;
                r_tc <= (r_tc == c_tc_last) ? '0 : r_tc + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_tc <= '0;
                    if (w_start_edge) begin
                        r_state   <= START;
                        r_bitcnt  <= '0;
                        r_stopcnt <= 1'b0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                    end
                end
                START: begin
                    if (w_decide && w_majority) r_state <= IDLE;
                    else if (w_bit_end)         r_state <= DATA;
                end
                DATA: begin
                    if (w_decide) r_shift <= {w_majority, r_shift[DATA_BITS-1:1]};
                    if (w_bit_end) begin
                        if (r_bitcnt == c_bit_last)
                            r_state <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                        else
                            r_bitcnt <= r_bitcnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_decide) begin
                        r_par_bit <= w_majority;
                        r_perr    <= (w_majority != w_par_exp);
                    end
                    if (w_bit_end) r_state <= STOP;
                end
                STOP: begin
                    if (w_decide) begin
                        r_ferr <= w_ferr_final;
                        // Leave half a bit early on a clean stop to resync on the next edge.
                        if (r_stopcnt == c_stop_last)
                            r_state <= w_ferr_final ? WAIT_HIGH : IDLE;
                    end else if (w_bit_end) begin
                        r_stopcnt <= r_stopcnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (w_rxs) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_word   <= '0;
            r_valid  <= 1'b0;
            r_perr_o <= 1'b0;
            r_ferr_o <= 1'b0;
            r_brk_o  <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_deliver && (!r_valid || rx_ready)) begin
                r_word   <= r_shift;
                r_perr_o <= (PARITY_MODE != PARITY_NONE) && r_perr;
                r_ferr_o <= w_ferr_final;
                r_brk_o  <= w_brk;
                r_valid  <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (w_xfer)                    r_ovr <= 1'b0;
            else if (w_deliver && r_valid) r_ovr <= 1'b1;
        end
    end

    assign rx_word     = r_word;
    assign rx_valid    = r_valid;
    assign parity_err  = r_perr_o;
    assign frame_err   = r_ferr_o;
    assign break_det   = r_brk_o;
    assign overrun_err = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Directed self-checking bench for uart_rx_param (8N1, 7E1, 7O1, 8N2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int c_clk_hz = 1843200;
    localparam int c_baud   = 115200;
    localparam int c_os     = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] rxl;
    logic [3:0] rdy;
    wire  [3:0] v, pe, fe, bd, oe;
    wire  [7:0] w0, w3;
    wire  [6:0] w1, w2;

    int total = 0;
    int bad   = 0;
    int lat;

    uart_rx_param #(.CLK_HZ(c_clk_hz), .BAUD(c_baud), .OVERSAMPLE(c_os),
                    .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clock(clk), .reset(rst_n), .rx_data(rxl[0]), .rx_word(w0), .rx_valid(v[0]),
        .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .break_det(bd[0]),
        .overrun_err(oe[0]));

    uart_rx_param #(.CLK_HZ(c_clk_hz), .BAUD(c_baud), .OVERSAMPLE(c_os),
                    .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_7e1 (
        .clock(clk), .reset(rst_n), .rx_data(rxl[1]), .rx_word(w1), .rx_valid(v[1]),
        .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .break_det(bd[1]),
        .overrun_err(oe[1]));

    uart_rx_param #(.CLK_HZ(c_clk_hz), .BAUD(c_baud), .OVERSAMPLE(c_os),
                    .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_7o1 (
        .clock(clk), .reset(rst_n), .rx_data(rxl[2]), .rx_word(w2), .rx_valid(v[2]),
        .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .break_det(bd[2]),
        .overrun_err(oe[2]));

    uart_rx_param #(.CLK_HZ(c_clk_hz), .BAUD(c_baud), .OVERSAMPLE(c_os),
                    .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
        .clock(clk), .reset(rst_n), .rx_data(rxl[3]), .rx_word(w3), .rx_valid(v[3]),
        .rx_ready(rdy[3]), .parity_err(pe[3]), .frame_err(fe[3]), .break_det(bd[3]),
        .overrun_err(oe[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives line bits LSB first (one bit = c_os clocks), then idle-high bits.
    // first_valid = negedge count from the start bit at which rx_valid was first seen.
    task automatic send(input int idx, input logic [15:0] bits, input int nbits,
                        input int idle_bits, output int first_valid);
        int cnt = 0;
        first_valid = -1;
        for (int i = 0; i < nbits + idle_bits; i++) begin
            rxl[idx] = (i < nbits) ? bits[i] : 1'b1;
            repeat (c_os) begin
                @(negedge clk);
                cnt++;
                if (first_valid < 0 && v[idx] === 1'b1) first_valid = cnt;
            end
        end
    endtask

    task automatic consume(input int idx, input string tag);
        rdy[idx] = 1'b1;
        @(negedge clk);
        rdy[idx] = 1'b0;
        chk(tag, 32'(v[idx]), 32'd0);
    endtask

    initial begin
        rxl   = '1;
        rdy   = '0;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_valid", 32'(v), 32'd0);
        chk("rst_flags", 32'({pe, fe, bd, oe}), 32'd0);
        chk("rst_word", 32'({w0, w1}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 0xA5: rx_valid 157 clocks after the start edge is driven
        // (2 sync + 1 edge detect + 9 bits*16 + 10 ticks into stop bit).
        send(0, 16'({1'b1, 8'hA5, 1'b0}), 10, 1, lat);
        chk("a5_latency", 32'(lat >= 157 && lat <= 158), 32'd1);
        chk("a5_valid", 32'(v[0]), 32'd1);
        chk("a5_word", 32'(w0), 32'hA5);
        chk("a5_flags", 32'({pe[0], fe[0], bd[0], oe[0]}), 32'd0);
        consume(0, "a5_consume");

        // 7E1 / 7O1 with 0x41 (two ones -> data XOR = 0)
        send(1, 16'({1'b1, 1'b0, 7'h41, 1'b0}), 10, 1, lat);
        chk("e_p0_valid", 32'(v[1]), 32'd1);
        chk("e_p0_word", 32'(w1), 32'h41);
        chk("e_p0_perr", 32'(pe[1]), 32'd0);
        consume(1, "e_p0_consume");
        send(1, 16'({1'b1, 1'b1, 7'h41, 1'b0}), 10, 1, lat);
        chk("e_p1_word", 32'(w1), 32'h41);
        chk("e_p1_perr", 32'(pe[1]), 32'd1);
        consume(1, "e_p1_consume");
        send(2, 16'({1'b1, 1'b0, 7'h41, 1'b0}), 10, 1, lat);
        chk("o_p0_perr", 32'(pe[2]), 32'd1);
        chk("o_p0_word", 32'(w2), 32'h41);
        consume(2, "o_p0_consume");
        send(2, 16'({1'b1, 1'b1, 7'h41, 1'b0}), 10, 1, lat);
        chk("o_p1_perr", 32'(pe[2]), 32'd0);
        chk("o_p1_fe", 32'(fe[2]), 32'd0);
        consume(2, "o_p1_consume");

        // Glitch of 5 ticks, then a real frame
        rxl[0] = 1'b0;
        repeat (5) @(negedge clk);
        rxl[0] = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_valid", 32'(v[0]), 32'd0);
        send(0, 16'({1'b1, 8'h3C, 1'b0}), 10, 1, lat);
        chk("3c_valid", 32'(v[0]), 32'd1);
        chk("3c_word", 32'(w0), 32'h3C);
        chk("3c_flags", 32'({pe[0], fe[0], bd[0], oe[0]}), 32'd0);
        consume(0, "3c_consume");

        // 8N2 0x55 with the second stop bit low
        send(3, 16'({1'b0, 1'b1, 8'h55, 1'b0}), 11, 2, lat);
        chk("n2_valid", 32'(v[3]), 32'd1);
        chk("n2_word", 32'(w3), 32'h55);
        chk("n2_fe", 32'(fe[3]), 32'd1);
        chk("n2_bd", 32'(bd[3]), 32'd0);
        consume(3, "n2_consume");

        // Break: line low for 20 bit times
        rxl[0] = 1'b0;
        repeat (20 * c_os) @(negedge clk);
        chk("brk_valid", 32'(v[0]), 32'd1);
        chk("brk_word", 32'(w0), 32'h00);
        chk("brk_fe_bd", 32'({fe[0], bd[0]}), 32'b11);
        consume(0, "brk_consume");
        repeat (5 * c_os) @(negedge clk);
        chk("brk_no_more_low", 32'({v[0], oe[0]}), 32'd0);
        rxl[0] = 1'b1;
        repeat (2 * c_os) @(negedge clk);
        chk("brk_no_more_high", 32'(v[0]), 32'd0);

        // Overrun: 0x11 held while 0x22 arrives
        send(0, 16'({1'b1, 8'h11, 1'b0}), 10, 1, lat);
        send(0, 16'({1'b1, 8'h22, 1'b0}), 10, 2, lat);
        chk("ovr_word", 32'(w0), 32'h11);
        chk("ovr_valid_oe", 32'({v[0], oe[0]}), 32'b11);
        consume(0, "ovr_consume");
        chk("ovr_cleared", 32'(oe[0]), 32'd0);

        // Reset during data bit 4 of 0xF0 while 0x5A is still held
        send(0, 16'({1'b1, 8'h5A, 1'b0}), 10, 1, lat);
        chk("pre_rst_word", 32'(w0), 32'h5A);
        send(0, 16'h0000, 5, 0, lat);
        rxl[0] = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(v), 32'd0);
        chk("midrst_flags", 32'({pe, fe, bd, oe}), 32'd0);
        chk("midrst_words", 32'({w0, w1, w3}), 32'd0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * c_os) @(negedge clk);
        chk("post_rst_idle", 32'(v[0]), 32'd0);
        send(0, 16'({1'b1, 8'h0F, 1'b0}), 10, 1, lat);
        chk("0f_valid", 32'(v[0]), 32'd1);
        chk("0f_word", 32'(w0), 32'h0F);
        chk("0f_flags", 32'({pe[0], fe[0], bd[0], oe[0]}), 32'd0);
        consume(0, "0f_consume");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised next-generation UART/IrDA-side serial receiver.
- Configurable data width, parity mode, stop-bit count and oversampling.
- Majority-vote sampling, start-bit glitch rejection, break detection.
- Presents received words on a valid/ready handshake with overrun detection; sits between the line input and the receive FIFO/display logic.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line bit rate.
- OVERSAMPLE, 16, sample ticks per bit; even, ≥8.
- DATA_BITS, 8, payload width; legal 5..9.
- PARITY_MODE, 0, 0=none, 1=even, 2=odd.
- STOP_BITS, 1, stop bits checked; 1 or 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  1  asynchronous serial line; idle high.
- rx_word  out  DATA_BITS  received payload, LSB = first bit on line.
- rx_valid  out  1  rx_word and the error flags hold an unconsumed frame.
- rx_ready  in  1  consumer accepts the frame this cycle.
- parity_err  out  1  parity mismatch for the held frame; 0 when PARITY_MODE=0.
- frame_err  out  1  a stop bit was sampled low for the held frame.
- break_det  out  1  held frame was all-zero data with a low stop bit.
- overrun_err  out  1  sticky: a frame was dropped because the holding register was full.

Behaviour:
- Clock and reset: one clock domain, `clock`. `reset` is asynchronous and active-low; asserting it at any time forces IDLE.
- Reset values:
  - Synchroniser flops reset to 1.
  - All outputs reset to 0.
  - Counters reset to 0.
- Input synchroniser: rx_data passes through a 2-flop synchroniser. All logic uses the synchronised value `rxs`. This adds 2 clocks of input latency.
- Tick generator:
  - DIV = CLK_HZ/(BAUD*OVERSAMPLE), rounded to nearest; minimum 1.
  - One-clock tick every DIV clocks.
  - Restarts (count 0) on entry to START.
  - Held at 0 while IDLE.
- Sampling: tick counter `tc` runs 0..OVERSAMPLE-1 within each bit. The bit value is the majority of rxs at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit decision is taken at tick OVERSAMPLE/2+1.
- States:
  - IDLE: on the rxs 1→0 transition, go to START.
  - START: at the decision point, majority 1 → IDLE (glitch, no output). Majority 0 → DATA at the end of the bit.
  - DATA: shift DATA_BITS bits, LSB first. After the last bit, go to PARITY if PARITY_MODE≠0, else STOP.
  - PARITY: compute the expected bit:
    - even mode: expected = XOR of the data bits.
    - odd mode: expected = the inverse of that XOR.
    - Mismatch sets pending parity_err.
  - STOP: sample STOP_BITS stop bits. Any 0 sets pending frame_err. At the decision point of the final stop bit, deliver the frame.
    - If all stop bits were 1, go to IDLE immediately (half-bit early, for resynchronisation).
    - Otherwise go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then IDLE. This prevents false starts during a break.
- Deliver (one clock after the final-stop decision):
  - Holding register empty, or consumed this same cycle (rx_valid & rx_ready): load rx_word and the three flags, set rx_valid. Load has priority over the clear.
  - Otherwise: discard the new frame, keep the old one, set overrun_err.
- Handshake:
  - Transfer occurs when rx_valid & rx_ready on a rising edge.
  - rx_valid falls the next cycle unless a new frame loads in the same cycle.
  - rx_word and the flags are stable while rx_valid=1.
  - rx_ready is ignored while rx_valid=0.
- overrun_err clears on the next successful transfer, or on reset.
- break_det = frame_err & (data == 0) & parity bit low (when parity is enabled).
- Mid-frame reset: the frame is aborted, nothing is delivered, and the line is re-acquired from IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - PARITY_NONE/EVEN/ODD constants.
  - State encoding for IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - Default OVERSAMPLE.
  - A function computing DIV from CLK_HZ, BAUD and OVERSAMPLE.
- One sub-module: uart_os_tick (enable-gated, restartable oversample tick generator). It is also reusable by the future parametrised transmitter.

Test Plan:
- Default frame: CLK_HZ=1843200, BAUD=115200 (DIV=1), 8N1; send 0xA5 → rx_word=0xA5, rx_valid=1 one clock after the final-stop decision (mid-stop-bit + 2-clock synchroniser), flags 0; with rx_ready=1 the next cycle, rx_valid drops.
- Parity: 7E1, send 0x41 with parity 0 → parity_err=0. Same data with parity 1 → parity_err=1, rx_word=0x41. Repeat in 7O1 with the inverted expectations.
- Glitch: a 0 pulse of 5 ticks on the idle line → no rx_valid, state returns to IDLE. A following valid frame 0x3C is received correctly.
- Frame error and break:
  - 8N2 frame 0x55 with second stop bit low → frame_err=1, break_det=0.
  - Line held low for 20 bit times → one frame with rx_word=0x00, frame_err=1, break_det=1. No further frames until the line returns high.
- Overrun: rx_ready=0, send 0x11 then 0x22 → rx_word stays 0x11, overrun_err=1. Pulse rx_ready → transfer of 0x11, overrun_err=0, rx_valid=0.
- Reset mid-frame: assert reset during data bit 4 of 0xF0 → all outputs 0 immediately (async). Release reset, send 0x0F → rx_word=0x0F, no errors.
